// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types and constants for the CPU run-control sequencer.
package cpu_seq_pkg;

  localparam int IMEM_AW_DEF = 10;
  localparam int CNT_W_DEF   = 32;

  // Branch-to-self (B . with AL condition) marks the end of a program.
  localparam logic [31:0] HALT_INSTR = 32'hEAFF_FFFE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Program-load stream and instruction-memory write port of the sequencer.
// master: load source / memory side, slave: the sequencer.
interface cpu_seq_ctrl_if
  import cpu_seq_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF
);
  logic               load_valid;
  logic               load_last;
  logic [31:0]        load_data;
  logic               load_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;

  modport master (
    output load_valid, load_last, load_data,
    input  load_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  load_valid, load_last, load_data,
    output load_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/cpu_seq_ctrl_seq_counter.sv
// Wrap-around event counter with synchronous clear and count enable.
module seq_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count enabled events; clear wins over enable, wrap is natural overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (clr) begin
      count <= {CNT_W{1'b0}};
    end else if (en) begin
      count <= count + CNT_ONE;
    end
  end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Run-control sequencer for the single-cycle ARM core: program load,
// free-run, single-step and halt, plus cycle / retired-instruction counters.
// Optional breakpoint support is compiled in with CPU_SEQ_BREAKPOINT_EN.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               load_start,
  cpu_seq_ctrl_if.slave      ld,
  input  logic [31:0]        pc,
  input  logic [31:0]        instr,
`ifdef CPU_SEQ_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
`endif
  output logic               cpu_start,
  output logic               cpu_reset,
  output logic               halted,
  output logic               load_ovf,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   retired
);
  localparam logic [IMEM_AW-1:0] ADDR_ZERO = {IMEM_AW{1'b0}};
  localparam logic [IMEM_AW-1:0] ADDR_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};
  localparam logic [IMEM_AW-1:0] ADDR_MAX  = {IMEM_AW{1'b1}};

  seq_state_t         state_r;
  seq_state_t         next_state_s;
  logic [IMEM_AW-1:0] addr_r;
  logic               load_ovf_r;
  logic               load_entry_s;
  logic               bp_hit_s;
  logic               cyc_en_s;

  assign load_entry_s  = (next_state_s == LOAD) && (state_r != LOAD);
  assign cyc_en_s      = (state_r == RUN) || (state_r == STEP);
  assign ld.imem_waddr = addr_r;
  assign ld.imem_wdata = ld.load_data;
  assign load_ovf      = load_ovf_r;

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic resume_first_r;

  // Flag the first RUN cycle after a resume so the core can leave the breakpoint
  always_ff @(posedge clk) begin
    if (!reset) begin
      resume_first_r <= 1'b0;
    end else begin
      resume_first_r <= (state_r == HALT) && (next_state_s == RUN);
    end
  end

  assign bp_hit_s = (state_r == RUN) && bp_en && (pc == bp_addr) && !resume_first_r;
`else
  logic unused_s;

  assign bp_hit_s = 1'b0;
  assign unused_s = ^pc;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; load_start has priority over step, step over run
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, HALT: begin
        if (load_start) begin
          next_state_s = LOAD;
        end else if (step) begin
          next_state_s = STEP;
        end else if (run) begin
          next_state_s = RUN;
        end else begin
          next_state_s = state_r;
        end
      end
      LOAD: begin
        if (ld.load_valid && ld.load_last) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LOAD;
        end
      end
      RUN: begin
        if (halt_req || (instr == HALT_INSTR) || bp_hit_s) begin
          next_state_s = HALT;
        end else begin
          next_state_s = RUN;
        end
      end
      STEP:    next_state_s = HALT;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the current state; PC stays at 0 while idle or loading
  always_comb begin
    cpu_start     = 1'b0;
    cpu_reset     = 1'b0;
    halted        = 1'b0;
    ld.load_ready = 1'b0;
    ld.imem_we    = 1'b0;
    case (state_r)
      IDLE: cpu_reset = 1'b1;
      LOAD: begin
        cpu_reset     = 1'b1;
        ld.load_ready = 1'b1;
        ld.imem_we    = ld.load_valid;
      end
      RUN:     cpu_start = !bp_hit_s;
      STEP:    cpu_start = 1'b1;
      HALT:    halted    = 1'b1;
      default: cpu_reset = 1'b1;
    endcase
  end

  // Load address and sticky overflow; both restart on every entry into LOAD
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r     <= ADDR_ZERO;
      load_ovf_r <= 1'b0;
    end else if (load_entry_s) begin
      addr_r     <= ADDR_ZERO;
      load_ovf_r <= 1'b0;
    end else if ((state_r == LOAD) && ld.load_valid) begin
      addr_r <= addr_r + ADDR_ONE;
      if ((addr_r == ADDR_MAX) && !ld.load_last) begin
        load_ovf_r <= 1'b1;
      end
    end
  end

  seq_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (load_entry_s),
    .en    (cyc_en_s),
    .count (cycles)
  );

  seq_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .reset (reset),
    .clr   (load_entry_s),
    .en    (cpu_start),
    .count (retired)
  );
endmodule
